towers_lane_engine: RTL

- Multi-object successor to the single falling-tower mover. Manages up to N_OBJ independently falling rectangles, each with its own X, fixed-point Y, and active flag.
- Spawns objects on request into the lowest free slot and advances every active object by a programmable speed once per frame.
- Retires objects that pass the screen bottom or are killed by the game logic.
- Produces one registered drawing request and offsets per VGA pixel for the VGA mux/bitmap stage.

---
 rtl/towers_lane_engine_if.sv | 12 +
 rtl/towers_lane_engine.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/towers_lane_engine_if.sv
// Spawn/kill handshake between the game logic (master) and the lane engine (slave).
interface towers_lane_engine_if;
  logic               spawnReq;
  logic signed [10:0] spawnX;
  logic               spawnAck;
  logic               spawnDrop;
  logic               killReq;
  logic [2:0]         killIdx;

  modport master (output spawnReq, spawnX, killReq, killIdx, input spawnAck, spawnDrop);
  modport slave  (input spawnReq, spawnX, killReq, killIdx, output spawnAck, spawnDrop);
endinterface

// File: rtl/towers_lane_engine.sv
// Multi-object falling-tower engine: per-slot movers plus spawn allocation,
// miss accounting and a registered lowest-index-wins draw request.
module towers_lane_slot #(
  parameter int OBJECT_WIDTH_X  = 20,
  parameter int OBJECT_HEIGHT_Y = 20,
  parameter int FRAC_BITS       = 6,
  parameter int SPEED_W         = 10,
  parameter int SCREEN_H        = 480
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sof,
  input  logic [SPEED_W-1:0]  speed,
  input  logic                spawn,
  input  logic signed [10:0]  spawn_x,
  input  logic                kill,
  input  logic [10:0]         pixel_x,
  input  logic [10:0]         pixel_y,
  output logic                active,
  output logic                retire,
  output logic                hit,
  output logic [10:0]         off_x,
  output logic [10:0]         off_y
);
  localparam int YW = 11 + FRAC_BITS;
  localparam logic signed [12:0] SCR = 13'(SCREEN_H);
  localparam logic signed [12:0] W13 = 13'(OBJECT_WIDTH_X);
  localparam logic signed [12:0] H13 = 13'(OBJECT_HEIGHT_Y);

  logic signed [YW-1:0] y_q, y_shr;
  logic signed [10:0]   x_q;
  logic                 act_q;
  logic signed [12:0]   left, top, px, py;

  // 13-bit signed workspace so left+width never wraps for any 11-bit position
  assign y_shr = y_q >>> FRAC_BITS;
  assign top   = {{2{y_shr[10]}}, y_shr[10:0]};
  assign left  = {{2{x_q[10]}}, x_q};
  assign px    = {2'b00, pixel_x};
  assign py    = {2'b00, pixel_y};

  assign active = act_q;
  assign retire = sof && act_q && !kill && (top > SCR);
  assign hit    = act_q && (px >= left) && (px < left + W13) &&
                  (py >= top) && (py < top + H13);
  assign off_x  = 11'(px - left);
  assign off_y  = 11'(py - top);

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (spawn) begin
      act_q <= 1'b1;
      x_q   <= spawn_x;
      y_q   <= '0;
    end else if (kill || retire) begin
      act_q <= 1'b0;
    end else if (sof && act_q) begin
      y_q <= y_q + $signed({{(YW-SPEED_W){1'b0}}, speed});
    end
  end
endmodule

module towers_lane_engine #(
  parameter int N_OBJ           = 4,
  parameter int OBJECT_WIDTH_X  = 20,
  parameter int OBJECT_HEIGHT_Y = 20,
  parameter int FRAC_BITS       = 6,
  parameter int SPEED_W         = 10,
  parameter int SCREEN_H        = 480,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic [SPEED_W-1:0]   speed,
  towers_lane_engine_if.slave  lane,
  output logic [N_OBJ-1:0]     activeMask,
  output logic                 drawingRequest,
  output logic [2:0]           drawIdx,
  output logic [10:0]          offsetX,
  output logic [10:0]          offsetY,
  output logic                 edgeCollide,
  output logic [CNT_W-1:0]     missCount
);
  logic [N_OBJ-1:0]       act, ret, hit, spawn_sel, kill_sel;
  logic [N_OBJ-1:0][10:0] off_x, off_y;
  logic                   any_free;
  logic                   d_hit;
  logic [2:0]             d_idx;
  logic [10:0]            d_ox, d_oy;
  logic [3:0]             n_ret;
  logic [CNT_W+3:0]       msum;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_slot
    assign kill_sel[g] = lane.killReq && (lane.killIdx == 3'(g));
    towers_lane_slot #(
      .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
      .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y),
      .FRAC_BITS      (FRAC_BITS),
      .SPEED_W        (SPEED_W),
      .SCREEN_H       (SCREEN_H)
    ) u_slot (
      .clk(clk), .reset(reset), .sof(startOfFrame), .speed(speed),
      .spawn(spawn_sel[g]), .spawn_x(lane.spawnX), .kill(kill_sel[g]),
      .pixel_x(pixelX), .pixel_y(pixelY),
      .active(act[g]), .retire(ret[g]), .hit(hit[g]),
      .off_x(off_x[g]), .off_y(off_y[g])
    );
  end

  // Only currently-inactive slots are free, so slots being killed or
  // retired this cycle are still busy for allocation.
  always_comb begin
    spawn_sel = '0;
    any_free  = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!any_free && !act[i]) begin
        any_free     = 1'b1;
        spawn_sel[i] = lane.spawnReq;
      end
    end
  end

  always_comb begin
    d_hit = 1'b0;
    d_idx = '0;
    d_ox  = '0;
    d_oy  = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!d_hit && hit[i]) begin
        d_hit = 1'b1;
        d_idx = 3'(i);
        d_ox  = off_x[i];
        d_oy  = off_y[i];
      end
    end
  end

  always_comb begin
    n_ret = '0;
    for (int i = 0; i < N_OBJ; i++) n_ret = n_ret + 4'(ret[i]);
    msum = {4'b0, missCount} + (CNT_W+4)'(n_ret);
  end

  assign activeMask = act;

  always_ff @(posedge clk) begin
    if (reset) begin
      lane.spawnAck  <= 1'b0;
      lane.spawnDrop <= 1'b0;
      drawingRequest <= 1'b0;
      drawIdx        <= '0;
      offsetX        <= '0;
      offsetY        <= '0;
      edgeCollide    <= 1'b0;
      missCount      <= '0;
    end else begin
      lane.spawnAck  <= lane.spawnReq && any_free;
      lane.spawnDrop <= lane.spawnReq && !any_free;
      drawingRequest <= d_hit;
      drawIdx        <= d_idx;
      offsetX        <= d_ox;
      offsetY        <= d_oy;
      edgeCollide    <= |ret;
      missCount      <= (msum > {4'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : msum[CNT_W-1:0];
    end
  end
endmodule
